// File: rtl/bp_pkg.sv
// Shared helpers for branch_predictor_table: counter reset value, saturating
// counter arithmetic and the table index hash.
package bp_pkg;

  // All-ones value of a w-bit counter (strongly taken); also its saturation ceiling.
  function automatic int unsigned ctr_reset(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned w);
    return (v >= ctr_reset(w)) ? v : v + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned v);
    return (v == 32'd0) ? v : v - 32'd1;
  endfunction

  // Word-aligned PC bits XOR history; the caller truncates to the index width.
  function automatic int unsigned idx_hash(input logic [31:0] pc, input int unsigned hist);
    return int'(pc >> 2) ^ hist;
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that increments when inc_i is high and holds at all ones.
module sat_counter32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predictor_table.sv
// PC-indexed table of saturating direction counters with perf counters.
// Define BP_GSHARE_EN to XOR a global resolve-time history into the index.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned HIST_W  = 4,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      pred_pc_i,
  output logic             predict_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             update_i,
  input  logic [IDX_W-1:0] update_idx_i,
  input  logic             result_i,
  input  logic             prev_predict_i,
  output logic [31:0]      branch_cnt_o,
  output logic [31:0]      miss_cnt_o
);

  logic             upd_en;
  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_next;
  logic [HIST_W-1:0] hist_q;

  assign upd_en = start_i && update_i;

`ifdef BP_GSHARE_EN
  // History only moves at resolve, so wrong-path branches never pollute it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hist_q <= '0;
    end else if (upd_en) begin
      hist_q <= {hist_q[HIST_W-2:0], result_i};
    end
  end
`else
  assign hist_q = '0;
`endif

  assign pred_idx_o = IDX_W'(idx_hash(pred_pc_i, 32'(hist_q)));
  // Read of the pre-edge table: a same-cycle update is deliberately not bypassed.
  assign predict_o  = start_i & ctr_q[pred_idx_o][CTR_W-1];

  assign upd_cur  = ctr_q[update_idx_i];
  assign upd_next = result_i ? CTR_W'(sat_inc(32'(upd_cur), CTR_W))
                             : CTR_W'(sat_dec(32'(upd_cur)));

  // NOTE: the table is flops, not RAM, so every entry takes the async reset;
  // a RAM-mapped array would have to leave its contents unreset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CTR_W'(ctr_reset(CTR_W));
      end
    end else if (upd_en) begin
      ctr_q[update_idx_i] <= upd_next;
    end
  end

  sat_counter32 u_branch_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (upd_en),
    .count_o (branch_cnt_o)
  );

  sat_counter32 u_miss_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (upd_en && (prev_predict_i != result_i)),
    .count_o (miss_cnt_o)
  );

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench for branch_predictor_table (ENTRIES=16, CTR_W=2); the
// gshare sequence is selected when BP_GSHARE_EN is defined.
module tb_branch_predictor_table;

  localparam int unsigned IDX_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic [31:0]      pred_pc_i = '0;
  logic             predict_o;
  logic [IDX_W-1:0] pred_idx_o;
  logic             update_i = 1'b0;
  logic [IDX_W-1:0] update_idx_i = '0;
  logic             result_i = 1'b0;
  logic             prev_predict_i = 1'b0;
  logic [31:0]      branch_cnt_o;
  logic [31:0]      miss_cnt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string            name;
    logic             pred;
    logic [IDX_W-1:0] idx;
    logic [31:0]      bcnt;
    logic [31:0]      mcnt;
  } exp_t;

  exp_t exp_q[$];
  logic sample_valid = 1'b0;

  branch_predictor_table #(.ENTRIES(16), .CTR_W(2), .HIST_W(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .pred_pc_i      (pred_pc_i),
    .predict_o      (predict_o),
    .pred_idx_o     (pred_idx_o),
    .update_i       (update_i),
    .update_idx_i   (update_idx_i),
    .result_i       (result_i),
    .prev_predict_i (prev_predict_i),
    .branch_cnt_o   (branch_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle whenever the stimulus marked the cycle observable.
  always @(negedge clk_i) begin
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: sample with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".pred"}, 32'(predict_o),  32'(e.pred));
        check({e.name, ".idx"},  32'(pred_idx_o), 32'(e.idx));
        check({e.name, ".bcnt"}, branch_cnt_o,    e.bcnt);
        check({e.name, ".mcnt"}, miss_cnt_o,      e.mcnt);
      end
    end
  end

  task automatic drive(input logic st, input logic [31:0] pc, input logic upd,
                       input logic [IDX_W-1:0] uidx, input logic res, input logic prev);
    start_i        = st;
    pred_pc_i      = pc;
    update_i       = upd;
    update_idx_i   = uidx;
    result_i       = res;
    prev_predict_i = prev;
  endtask

  task automatic expect_out(input string name, input logic pred, input logic [IDX_W-1:0] idx,
                            input logic [31:0] b, input logic [31:0] m);
    exp_t e;
    e.name = name;
    e.pred = pred;
    e.idx  = idx;
    e.bcnt = b;
    e.mcnt = m;
    exp_q.push_back(e);
    sample_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic run_bimodal();
    // Two not-taken at idx 3, both mispredicted: counter 3 -> 2 -> 1.
    drive(1, 32'h0C, 1, 4'd3, 0, 1); expect_out("nt1", 1, 4'd3, 0, 0); tick();
    drive(1, 32'h0C, 1, 4'd3, 0, 1); expect_out("nt2", 1, 4'd3, 1, 1); tick();
    drive(1, 32'h0C, 0, 4'd0, 0, 0); expect_out("idx3_weak", 0, 4'd3, 2, 2); tick();
    drive(1, 32'h10, 0, 4'd0, 0, 0); expect_out("idx4_untouched", 1, 4'd4, 2, 2); tick();
    // Five taken, correctly predicted: 1 -> 2 -> 3 -> 3 -> 3 -> 3.
    drive(1, 32'h0C, 1, 4'd3, 1, 1); expect_out("t1", 0, 4'd3, 2, 2); tick();
    drive(1, 32'h0C, 1, 4'd3, 1, 1); expect_out("t2", 1, 4'd3, 3, 2); tick();
    drive(1, 32'h0C, 1, 4'd3, 1, 1); expect_out("t3", 1, 4'd3, 4, 2); tick();
    drive(1, 32'h0C, 1, 4'd3, 1, 1); expect_out("t4", 1, 4'd3, 5, 2); tick();
    drive(1, 32'h0C, 1, 4'd3, 1, 1); expect_out("t5", 1, 4'd3, 6, 2); tick();
    // One not-taken from saturation leaves counter 2: still taken.
    drive(1, 32'h0C, 1, 4'd3, 0, 1); expect_out("nt_from_sat", 1, 4'd3, 7, 2); tick();
    drive(1, 32'h0C, 0, 4'd0, 0, 0); expect_out("sat_hold", 1, 4'd3, 8, 3); tick();
    // Aliased PC 0x4C predicts and updates idx 3 in the same cycle: no bypass.
    drive(1, 32'h4C, 1, 4'd3, 0, 1); expect_out("same_cycle", 1, 4'd3, 8, 3); tick();
    drive(1, 32'h4C, 0, 4'd0, 0, 0); expect_out("after_same", 0, 4'd3, 9, 4); tick();
    // start low: updates ignored and prediction forced low.
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0C, 1, 4'd3, 1, 0); expect_out("stopped", 0, 4'd3, 9, 4); tick();
    end
    drive(1, 32'h0C, 0, 4'd0, 0, 0); expect_out("restart_idx3", 0, 4'd3, 9, 4); tick();
    drive(1, 32'h10, 0, 4'd0, 0, 0); expect_out("restart_idx4", 1, 4'd4, 9, 4); tick();
    // Floor: three not-taken from 1 must stop at 0; one taken then gives 1.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0C, 1, 4'd3, 0, 0); tick();
    end
    drive(1, 32'h0C, 1, 4'd3, 1, 0); expect_out("floor_inc", 0, 4'd3, 12, 4); tick();
    drive(1, 32'h0C, 0, 4'd0, 0, 0); expect_out("floor_hold", 0, 4'd3, 13, 5); tick();
    // Reset mid-operation with an update in flight.
    drive(0, 32'h10, 1, 4'd4, 0, 1);
    rst_i = 1'b0;
    expect_out("mid_rst", 0, 4'd4, 0, 0); tick();
    rst_i = 1'b1;
    drive(1, 32'h0C, 0, 4'd0, 0, 0); expect_out("post_rst_idx3", 1, 4'd3, 0, 0); tick();
    drive(1, 32'h10, 0, 4'd0, 0, 0); expect_out("post_rst_idx4", 1, 4'd4, 0, 0); tick();
  endtask

  task automatic run_gshare();
    // Same-cycle update uses old history (0) for the index.
    drive(1, 32'h0C, 1, 4'd0, 1, 1); expect_out("g_same", 1, 4'd3, 0, 0); tick();
    drive(1, 32'h0C, 0, 4'd0, 0, 0); expect_out("g_hist1", 1, 4'd2, 1, 0); tick();
    drive(1, 32'h0C, 1, 4'd2, 0, 1); expect_out("g_upd2a", 1, 4'd2, 1, 0); tick();
    drive(1, 32'h00, 1, 4'd2, 0, 1); expect_out("g_upd2b", 1, 4'd2, 2, 1); tick();
    drive(1, 32'h18, 0, 4'd0, 0, 0); expect_out("g_weak2", 0, 4'd2, 3, 2); tick();
    drive(0, 32'h18, 1, 4'd2, 1, 0);
    rst_i = 1'b0;
    expect_out("g_mid_rst", 0, 4'd6, 0, 0); tick();
    rst_i = 1'b1;
    drive(1, 32'h0C, 0, 4'd0, 0, 0); expect_out("g_post_rst", 1, 4'd3, 0, 0); tick();
    drive(1, 32'h08, 0, 4'd0, 0, 0); expect_out("g_ctr2_reset", 1, 4'd2, 0, 0); tick();
  endtask

  initial begin
    drive(0, 32'h40, 0, 4'd0, 0, 0);
    rst_i = 1'b0;
    tick();
    expect_out("in_reset", 0, 4'd0, 0, 0); tick();
    rst_i = 1'b1;
    drive(1, 32'h40, 0, 4'd0, 0, 0); expect_out("reset_state", 1, 4'd0, 0, 0); tick();
`ifdef BP_GSHARE_EN
    run_gshare();
`else
    run_bimodal();
`endif
    drive(0, 32'h0, 0, 4'd0, 0, 0);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised branch direction predictor that replaces the single global 2-bit saturating counter with a PC-indexed table of N-bit saturating counters. It can optionally XOR a global taken/not-taken history into the index (gshare). The block sits beside the ID stage: it predicts combinationally for the branch in IF/ID and is updated at the clock edge by the branch resolving in EX. It also keeps branch and mispredict performance counters.

## Interface
- ENTRIES, 16: number of counters; power of two, at least 2. IDX_W = log2(ENTRIES).
- CTR_W, 2: counter width in bits; at least 1.
- HIST_W, 4: global history length; at most IDX_W. Used only with BP_GSHARE_EN.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  run enable. When low: no state updates, predict_o = 0.
- pred_pc_i  input  32  PC of the instruction in ID (IF_ID PC).
- predict_o  output  1  1 = predict taken. Combinational.
- pred_idx_o  output  IDX_W  table index used for this prediction. Carried through ID_EX with the branch.
- update_i  input  1  a branch is resolving in EX this cycle.
- update_idx_i  input  IDX_W  pred_idx_o value carried through ID_EX.
- result_i  input  1  actual outcome, 1 = taken.
- prev_predict_i  input  1  prediction that was made for the resolving branch.
- branch_cnt_o  output  32  number of resolved branches (saturating).
- miss_cnt_o  output  32  number of mispredicted branches (saturating).

## Operation
- Table: ENTRIES counters, each CTR_W bits. A counter predicts taken when its MSB is 1.
- Index without the macro: pred_pc_i[IDX_W+1:2]. PC bits [1:0] are ignored.
- Index with the macro: pred_pc_i[IDX_W+1:2] XOR the history register, zero-extended to IDX_W.
- predict_o = start_i & MSB(table[pred_idx_o]).
- Update: fires on a rising edge when start_i && update_i.
  - Taken: table[update_idx_i] increments, saturating at 2^CTR_W − 1.
  - Not taken: table[update_idx_i] decrements, saturating at 0.
  - Only that one entry changes.
- History, macro on: on each update, hist ← {hist[HIST_W−2:0], result_i}. History is non-speculative; it changes only at resolve.
- Performance counters, on each update:
  - branch_cnt_o increments.
  - miss_cnt_o increments when prev_predict_i != result_i.
  - Both hold at 32'hFFFF_FFFF once reached.
- Aliasing: PCs with equal index bits share one entry. This is intended; there are no tags.

## Timing
- Reset: asynchronous on rst_i falling, held while rst_i is low.
  - Every counter = all ones (strongly taken).
  - History = 0; branch_cnt_o = 0; miss_cnt_o = 0.
  - predict_o = 0 (start_i is low during reset).
- Prediction latency is 0 cycles; predict_o and pred_idx_o follow pred_pc_i combinationally.
- Update latency is 1 edge; the new counter value is visible from the next cycle.
- Predict and update to the same index in the same cycle: predict_o reflects the pre-update value. There is no bypass.
- With the macro, a same-cycle update changes history only after the edge. The prediction in that cycle uses the old history.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight update is dropped.
- start_i low while update_i is high: the update is ignored; counters and history are unchanged.

## Configuration
- BP_GSHARE_EN defined:
  - History register of HIST_W bits is built.
  - Index = PC bits XOR history.
- BP_GSHARE_EN undefined:
  - No history register is built; HIST_W is unused.
  - Index = PC bits only.
  - Behaves as a bimodal table; with ENTRIES=2, CTR_W=2 this gives per-parity 2-bit prediction.

## Structure
- Shared package `bp_pkg`:
  - Counter reset constant (all-ones function of CTR_W).
  - Saturating increment/decrement functions.
  - Index-hash function.
- Sub-module `sat_counter32`: 32-bit saturating event counter with enable. Instantiated twice, for branch_cnt_o and miss_cnt_o.
- The table is a flop array (not a RAM), because it needs asynchronous reset and a combinational read.

## Test plan
All scenarios use ENTRIES=16, CTR_W=2 unless stated.

1. Reset, start_i=1, pred_pc_i=0x0000_0040 → predict_o=1, pred_idx_o=0; both perf counters 0.
2. Two not-taken updates at idx 3 with prev_predict_i=1 → pred_pc_i=0x0C gives predict_o=0; pred_pc_i=0x10 (idx 4) gives predict_o=1; miss_cnt_o=2, branch_cnt_o=2.
3. Continuing from 2 (counter 1), five taken updates at idx 3 → counter saturates at 3. One further not-taken → predict_o for 0x0C stays 1.
4. Same cycle: pred_pc_i=0x4C (aliases to idx 3) and a not-taken update at idx 3 from counter 2 → predict_o=1 that cycle, 0 the next.
5. BP_GSHARE_EN, HIST_W=4: one taken update → history=4'b0001; pred_pc_i=0x0C gives pred_idx_o=2. Assert rst_i low mid-sequence → history=0 and all counters=3 immediately.
6. start_i=0 with update_i=1 for 3 cycles → predict_o=0; table and counters are unchanged once start_i returns to 1.
